ps2_keyboard_rx: RTL
====================

Name: ps2_keyboard_rx

Overview:
- Receives PS/2 keyboard frames (device-to-host) and presents scan codes to the MiniAlu core through a one-deep holding register with a valid/ack handshake.
- Provides the input path of the CPU/VGA system; the VGA path is output only.
- Runs entirely on the 50 MHz system Clock. PS/2 lines are sampled asynchronously, synchronised, then glitch-filtered.

Parameters:
- FILTER_DEPTH, 8, length of the shift filter on the synchronised PS/2 clock and data (≥2).
- TIMEOUT_CYCLES, 50000, number of system cycles without a PS/2 falling edge that aborts a partial frame (1 ms at 50 MHz).

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high reset
- iPS2_CLK  in  1  raw PS/2 clock line, idle high
- iPS2_DATA  in  1  raw PS/2 data line, idle high
- iAck  in  1  consumer pulse; clears oValid and oOverrun
- oScanCode  out  8  last accepted byte
- oValid  out  1  oScanCode holds an unconsumed byte
- oParityError  out  1  one-cycle pulse: frame discarded for bad parity
- oFrameError  out  1  one-cycle pulse: frame discarded for bad stop bit
- oOverrun  out  1  sticky: a good frame was dropped while oValid=1
- oBusy  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, active-high): all outputs 0. Synchroniser and filter registers preset to all ones. Filtered clock and filtered data = 1. FSM = IDLE. Bit counter and timeout counter = 0.
- Input conditioning: 2-flop synchroniser per line, then a FILTER_DEPTH shift register.
  - Filtered level goes to 1 only when the register is all ones, and to 0 only when it is all zeros; otherwise it holds.
  - A falling edge is filtered clock 1→0 between consecutive cycles. All sampling happens on that cycle and uses the filtered data.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on falling edge, if data=0 (start bit) → DATA with bit count 0. If data=1, ignore and stay in IDLE.
  - DATA: on each falling edge, shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: on falling edge, capture the parity bit → STOP.
  - STOP: on falling edge → IDLE and evaluate the frame:
    - XOR of the 8 data bits and the parity bit = 0 (parity not odd): pulse oParityError, discard the frame.
    - Else stop bit = 0: pulse oFrameError, discard the frame.
    - Else (good frame): deliver the byte.
    - If parity and stop are both wrong, only oParityError pulses.
- Delivery of a good byte, one cycle after the stop-bit falling edge:
  - If oValid=0, or iAck=1 in that same cycle: load oScanCode and set oValid=1.
  - Else (oValid=1, no iAck): oScanCode is unchanged and oOverrun is set.
- Handshake:
  - oValid holds until iAck.
  - iAck while oValid=0 has no effect, except that it still clears oOverrun.
  - iAck clears oOverrun in the same cycle it clears oValid.
- Timeout: the counter clears on every falling edge and in IDLE. In any other state it increments; on reaching TIMEOUT_CYCLES the FSM returns to IDLE with no error pulse and no output change.
- oBusy = 1 in DATA, PARITY and STOP.
- Reset mid-frame: partial data is lost and the FSM restarts in IDLE.

Optional Feature:
- Macro: PS2_BREAK_DECODE_EN.
- Defined:
  - Adds output oBreak (1 bit, reset 0).
  - A good 0xF0 byte is not delivered; it sets an internal pending flag instead.
  - The next good byte is delivered with oBreak=1, and the flag clears. oBreak follows oScanCode and is loaded and held with it.
  - Parity or stop errors also clear the pending flag.
- Undefined: 0xF0 is delivered like any other byte, and the oBreak port does not exist.

Test Plan:
- Bench setup: PS/2 half-period 40 Clock cycles, TIMEOUT_CYCLES=200.
- Good frame: send 0x1C with bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1 → oScanCode=0x1C, oValid=1 one cycle after the stop-bit edge, held until iAck; then oValid=0.
- Parity error: send 0x1C with parity 1 → one-cycle oParityError, oValid stays 0, oScanCode unchanged. A following good 0x5A (parity 1) → oScanCode=0x5A.
- Overrun: send 0x1C then 0x32 (parity 0) with no iAck → oScanCode=0x1C, oOverrun=1. Pulse iAck → oValid=0, oOverrun=0.
- Glitch/timeout:
  - 3-cycle low pulse on iPS2_CLK while idle → oBusy stays 0, no output change.
  - Start bit plus 4 data bits, then 250 idle cycles → oBusy returns to 0.
  - Next frame 0x5A is received correctly.
- Break code: send 0xF0 (parity 1) then 0x1C.
  - With PS2_BREAK_DECODE_EN: a single oValid with oScanCode=0x1C, oBreak=1.
  - Without it: 0xF0 then 0x1C, each acked in turn.

Source files
------------

// File: rtl/ps2_keyboard_rx_if.sv
// rtl/ps2_keyboard_rx_if.sv - scan-code handshake bundle between the PS/2 receiver and its consumer
// oBreak exists only when PS2_BREAK_DECODE_EN is defined.
interface ps2_keyboard_rx_if;
  logic [7:0] oScanCode;
  logic       oValid;
  logic       iAck;
  logic       oParityError;
  logic       oFrameError;
  logic       oOverrun;
  logic       oBusy;
`ifdef PS2_BREAK_DECODE_EN
  logic       oBreak;
`endif

  modport master (
    output oScanCode, oValid, oParityError, oFrameError, oOverrun, oBusy,
`ifdef PS2_BREAK_DECODE_EN
    output oBreak,
`endif
    input  iAck
  );

  modport slave (
    input  oScanCode, oValid, oParityError, oFrameError, oOverrun, oBusy,
`ifdef PS2_BREAK_DECODE_EN
    input  oBreak,
`endif
    output iAck
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 device-to-host frame receiver with one-deep scan-code holding register
// Optional break-code folding (0xF0 prefix -> oBreak) under macro PS2_BREAK_DECODE_EN.
module ps2_keyboard_rx #(
  parameter int FILTER_DEPTH   = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iPS2_CLK,
  input  logic             iPS2_DATA,
  ps2_keyboard_rx_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} stateT;

  stateT                   state;
  logic [1:0]              clkSync, dataSync;
  logic [FILTER_DEPTH-1:0] clkShift, dataShift;
  logic                    clkFilt, dataFilt, clkFiltD;
  logic [7:0]              shiftReg;
  logic [2:0]              bitCnt;
  logic                    parityBit;
  logic [TW-1:0]           timeoutCnt;

  logic fallEdge, frameDone, goodFrame, deliver;

  assign fallEdge  = clkFiltD & ~clkFilt;
  assign frameDone = (state == STOP) && fallEdge;
  // Odd parity: data bits plus parity bit must XOR to 1.
  assign goodFrame = frameDone && (^{shiftReg, parityBit}) && dataFilt;

`ifdef PS2_BREAK_DECODE_EN
  logic breakPending;
  assign deliver = goodFrame && (shiftReg != 8'hF0);
`else
  assign deliver = goodFrame;
`endif

  assign bus.oBusy = (state != IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state            <= IDLE;
      clkSync          <= '1;
      dataSync         <= '1;
      clkShift         <= '1;
      dataShift        <= '1;
      clkFilt          <= 1'b1;
      dataFilt         <= 1'b1;
      clkFiltD         <= 1'b1;
      shiftReg         <= '0;
      bitCnt           <= '0;
      parityBit        <= 1'b0;
      timeoutCnt       <= '0;
      bus.oScanCode    <= '0;
      bus.oValid       <= 1'b0;
      bus.oParityError <= 1'b0;
      bus.oFrameError  <= 1'b0;
      bus.oOverrun     <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
      bus.oBreak       <= 1'b0;
      breakPending     <= 1'b0;
`endif
    end else begin
      clkSync   <= {clkSync[0], iPS2_CLK};
      dataSync  <= {dataSync[0], iPS2_DATA};
      clkShift  <= {clkShift[FILTER_DEPTH-2:0], clkSync[1]};
      dataShift <= {dataShift[FILTER_DEPTH-2:0], dataSync[1]};
      // Level changes only once the whole window agrees; otherwise hold.
      if (&clkShift)       clkFilt <= 1'b1;
      else if (~|clkShift) clkFilt <= 1'b0;
      if (&dataShift)       dataFilt <= 1'b1;
      else if (~|dataShift) dataFilt <= 1'b0;
      clkFiltD <= clkFilt;

      bus.oParityError <= 1'b0;
      bus.oFrameError  <= 1'b0;
      if (bus.iAck) begin
        bus.oValid   <= 1'b0;
        bus.oOverrun <= 1'b0;
      end

      if (state == IDLE || fallEdge) timeoutCnt <= '0;
      else                           timeoutCnt <= timeoutCnt + TW'(1);

      case (state)
        IDLE:
          if (fallEdge && !dataFilt) begin
            state  <= DATA;
            bitCnt <= '0;
          end
        DATA:
          if (fallEdge) begin
            shiftReg <= {dataFilt, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) state <= PARITY;
          end
        PARITY:
          if (fallEdge) begin
            parityBit <= dataFilt;
            state     <= STOP;
          end
        STOP:
          if (fallEdge) begin
            state <= IDLE;
            if (!(^{shiftReg, parityBit})) bus.oParityError <= 1'b1;
            else if (!dataFilt)            bus.oFrameError  <= 1'b1;
          end
        default: state <= IDLE;
      endcase

      // A stalled frame is abandoned silently.
      if (state != IDLE && !fallEdge && timeoutCnt == TW'(TIMEOUT_CYCLES - 1))
        state <= IDLE;

      if (deliver) begin
        if (!bus.oValid || bus.iAck) begin
          bus.oScanCode <= shiftReg;
          bus.oValid    <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
          bus.oBreak    <= breakPending;
`endif
        end else begin
          bus.oOverrun <= 1'b1;
        end
      end

`ifdef PS2_BREAK_DECODE_EN
      if (frameDone) breakPending <= goodFrame && (shiftReg == 8'hF0);
`endif
    end
  end
endmodule
